// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding, common to the receive and transmit blocks.
package uart_pkg;

    localparam int DEF_CLK_FREQ     = 100_000_000;
    localparam int DEF_BAUD         = 9600;
    localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;
    localparam int DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 2;
    localparam int DATA_BITS        = 8;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t S_IDLE  = 2'd0;
    localparam uart_state_t S_START = 2'd1;
    localparam uart_state_t S_DATA  = 2'd2;
    localparam uart_state_t S_STOP  = 2'd3;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line and enable in, byte and status strobes out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_en;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 done;
    logic                 busy;
    logic                 err;

    modport master (output rx_en, rx, input  data, done, busy, err);
    modport slave  (input  rx_en, rx, output data, done, busy, err);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_f1;
    logic r_f2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f1 <= RST_VAL;
            r_f2 <= RST_VAL;
        end else begin
            r_f1 <= i_d;
            r_f2 <= r_f1;
        end
    end

    assign o_q = r_f2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a down-counter, byte out with done/err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic clk,
    input  logic rst,
    uart_rx_if.slave bus
);

    localparam int HALF = half_bit(CLKS_PER_BIT);
    localparam int CW   = $clog2(CLKS_PER_BIT);

    uart_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_err;
    logic                 r_busy;
    logic                 w_rx_s;
    logic                 w_exp;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    assign w_exp = (r_cnt == '0);

    // Expiry costs one extra cycle, so reloading CLKS_PER_BIT-1 spaces samples exactly one bit apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_en && !w_rx_s) begin
                        r_cnt   <= CW'(HALF);
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!w_exp) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (!w_rx_s) begin
                        r_cnt   <= CW'(CLKS_PER_BIT - 1);
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_exp) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_shift[r_bit] <= w_rx_s;
                        r_cnt          <= CW'(CLKS_PER_BIT - 1);
                        if (r_bit == 3'(DATA_BITS - 1)) r_state <= S_STOP;
                        else                            r_bit   <= r_bit + 3'd1;
                    end
                end
                S_STOP: begin
                    if (!w_exp) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        // Leave at mid-stop-bit so the next start edge is caught early.
                        if (w_rx_s) begin
                            r_data <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_err  <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data = r_data;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectations from the bit-timing rules, checked every cycle.
module tb_uart_rx;

    localparam int C    = 20;
    localparam int HALF = C / 2;

    typedef struct {
        int         t0;
        int         e;
        int         kind;   // 0 = no strobe, 1 = done, 2 = err
        logic [7:0] d;
    } rec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   started;
    rec_t q[$];
    logic [7:0] model_data;
    int   done_cnt, err_cnt, busy_cnt;

    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD(50_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: a frame whose pin falls after edge p is first seen in IDLE at edge p+3;
    // busy covers [t0, end), the strobe and new data appear exactly at edge end.
    always @(negedge clk) begin
        logic eb, ed, ee;
        if (started && !rst) begin
            while (q.size() > 0 && cyc > q[0].e) void'(q.pop_front());
            eb = (q.size() > 0) && cyc >= q[0].t0 && cyc < q[0].e;
            ed = (q.size() > 0) && cyc == q[0].e && q[0].kind == 1;
            ee = (q.size() > 0) && cyc == q[0].e && q[0].kind == 2;
            if (ed) model_data = q[0].d;
            chk("busy", bus.busy, eb);
            chk("done", bus.done, ed);
            chk("err",  bus.err,  ee);
            chk("data", bus.data, model_data);
            if (bus.done) done_cnt++;
            if (bus.err)  err_cnt++;
            if (bus.busy) busy_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called and returns #1 after a clock edge; each bit is held exactly C cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int drop_en,
                              input int rst_at, input bit expect_rx);
        logic [9:0] bits;
        int p, w, t0, e;
        bits = {stop, b, 1'b0};
        p  = cyc;
        t0 = p + 3;
        e  = t0 + HALF + 1 + 9 * C;
        if (expect_rx) begin
            q.push_back('{t0, e, stop ? 1 : 2, b});
            if (!stop) q.push_back('{e + 1, e + 1 + HALF + 1, 0, 8'h00});
        end
        for (int i = 0; i < 10; i++) begin
            bus.rx = bits[i];
            if (i == drop_en) bus.rx_en = 1'b0;
            w = C;
            if (i == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                q.delete();
                model_data = 8'h00;
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_done", bus.done, 1'b0);
                chk("rst_err",  bus.err,  1'b0);
                chk("rst_data", bus.data, 8'h00);
                w = C - 1;
            end
            repeat (w) @(posedge clk);
            #1;
        end
        bus.rx    = 1'b1;
        bus.rx_en = 1'b1;
    endtask

    task automatic glitch(input int len);
        int p;
        p = cyc;
        q.push_back('{p + 3, p + 3 + HALF + 1, 0, 8'h00});
        bus.rx = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        bus.rx = 1'b1;
    endtask

    initial begin
        int d0, e0;
        n_cmp = 0; n_bad = 0; started = 0;
        done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        model_data = 8'h00;
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.rx_en = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_err",  bus.err,  1'b0);
        chk("reset_data", bus.data, 8'h00);
        started = 1;
        bus.rx_en = 1'b1;
        idle(5);

        // Single 0xA5 frame; busy spans HALF+1+9*C = 191 cycles
        d0 = done_cnt; busy_cnt = 0;
        send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
        idle(20);
        chk("a5_data", bus.data, 8'hA5);
        chk("a5_done_cnt", done_cnt - d0, 1);
        chk("a5_busy_len", busy_cnt, 191);

        // Back-to-back 0x00, 0xFF
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, -1, -1, 1'b1);
        send_frame(8'hFF, 1'b1, -1, -1, 1'b1);
        idle(20);
        chk("b2b_done_cnt", done_cnt - d0, 2);
        chk("b2b_data", bus.data, 8'hFF);

        // Framing error on 0x3C
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1, -1, 1'b1);
        idle(30);
        chk("ferr_err_cnt", err_cnt - e0, 1);
        chk("ferr_done_cnt", done_cnt - d0, 0);
        chk("ferr_data", bus.data, 8'hFF);

        // Short low glitch
        d0 = done_cnt; e0 = err_cnt; busy_cnt = 0;
        glitch(5);
        idle(30);
        chk("glitch_busy_len", busy_cnt, HALF + 1);
        chk("glitch_strobes", (done_cnt - d0) + (err_cnt - e0), 0);

        // Receiver disabled
        d0 = done_cnt; e0 = err_cnt; busy_cnt = 0;
        bus.rx_en = 1'b0;
        send_frame(8'h55, 1'b1, -1, -1, 1'b0);
        idle(20);
        chk("dis_busy_len", busy_cnt, 0);
        chk("dis_strobes", (done_cnt - d0) + (err_cnt - e0), 0);

        // Enable dropped during data bit 3
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, 4, -1, 1'b1);
        idle(20);
        chk("drop_done_cnt", done_cnt - d0, 1);
        chk("drop_data", bus.data, 8'h55);

        // Reset during data bit 4, then 0x81
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hF3, 1'b1, -1, 5, 1'b1);
        idle(20);
        chk("rstf_strobes", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("rstf_data", bus.data, 8'h00);
        send_frame(8'h81, 1'b1, -1, -1, 1'b1);
        idle(20);
        chk("post_rst_data", bus.data, 8'h81);
        chk("post_rst_done_cnt", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
